// File: rtl/pipe_hazard_ctrl_if.sv
// ============================================================================
// Module      : pipe_hazard_ctrl_if
// Description : Hazard-info / pipeline-control bundle between datapath and
//               pipe_hazard_ctrl. Optional statistics signals: PIPE_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipe_hazard_ctrl_if #(
    parameter int REG_BITS = 5
);
    logic [REG_BITS-1:0] fd_rs1;
    logic [REG_BITS-1:0] fd_rs2;
    logic                fd_uses_rs2;
    logic                dx_is_load;
    logic [REG_BITS-1:0] dx_rd;
    logic                branch_taken;
    logic                md_start;
    logic                md_ready;
    logic                pc_en;
    logic                fd_en;
    logic                fd_clr;
    logic                dx_en;
    logic                dx_clr;
    logic                xm_clr;
    logic                md_go;
    logic                md_err;
`ifdef PIPE_STATS_EN
    logic [31:0]         stall_cnt;
    logic [15:0]         flush_cnt;
`endif

    // master: datapath side, slave: the controller
    modport master (
        output fd_rs1, fd_rs2, fd_uses_rs2, dx_is_load, dx_rd,
               branch_taken, md_start, md_ready,
        input  pc_en, fd_en, fd_clr, dx_en, dx_clr, xm_clr, md_go, md_err
`ifdef PIPE_STATS_EN
        , input stall_cnt, flush_cnt
`endif
    );

    modport slave (
        input  fd_rs1, fd_rs2, fd_uses_rs2, dx_is_load, dx_rd,
               branch_taken, md_start, md_ready,
        output pc_en, fd_en, fd_clr, dx_en, dx_clr, xm_clr, md_go, md_err
`ifdef PIPE_STATS_EN
        , output stall_cnt, flush_cnt
`endif
    );
endinterface

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : 5-stage pipeline stall/flush controller with multdiv wait FSM
//               and watchdog. Optional counters enabled by PIPE_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl #(
    parameter int REG_BITS      = 5,
    parameter int MD_MAX_CYCLES = 64,
    parameter int CNT_W         = 7
) (
    input  wire                  clk,
    input  wire                  reset,
    pipe_hazard_ctrl_if.slave    bus
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_MDWAIT = 1'b1
    } state_t;

    localparam logic [REG_BITS-1:0] c_reg_zero = {REG_BITS{1'b0}};
    localparam logic [CNT_W-1:0]    c_wd_last  = CNT_W'(MD_MAX_CYCLES - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_wd;
    logic               r_md_err;

    logic w_load_use;
    logic w_timeout;
    logic w_pc_en, w_fd_en, w_fd_clr, w_dx_en, w_dx_clr, w_xm_clr, w_md_go;

    assign w_load_use = bus.dx_is_load && (bus.dx_rd != c_reg_zero) &&
                        ((bus.fd_rs1 == bus.dx_rd) ||
                         (bus.fd_uses_rs2 && (bus.fd_rs2 == bus.dx_rd)));
    assign w_timeout  = (r_wd == c_wd_last);

    always_comb begin
        w_pc_en  = 1'b1;
        w_fd_en  = 1'b1;
        w_fd_clr = 1'b0;
        w_dx_en  = 1'b1;
        w_dx_clr = 1'b0;
        w_xm_clr = 1'b0;
        w_md_go  = 1'b0;
        if (reset) begin
            w_pc_en  = 1'b0;
            w_fd_en  = 1'b0;
            w_fd_clr = 1'b1;
            w_dx_en  = 1'b0;
            w_dx_clr = 1'b1;
            w_xm_clr = 1'b1;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (bus.branch_taken) begin
                        w_fd_clr = 1'b1;
                        w_dx_clr = 1'b1;
                    end else if (bus.md_start) begin
                        w_md_go  = 1'b1;
                        w_pc_en  = 1'b0;
                        w_fd_en  = 1'b0;
                        w_dx_en  = 1'b0;
                        w_xm_clr = 1'b1;
                    end else if (w_load_use) begin
                        w_pc_en  = 1'b0;
                        w_fd_en  = 1'b0;
                        w_dx_clr = 1'b1;
                    end
                end
                ST_MDWAIT: begin
                    // A watchdog expiry releases the pipe exactly like md_ready
                    if (!bus.md_ready && !w_timeout) begin
                        w_pc_en  = 1'b0;
                        w_fd_en  = 1'b0;
                        w_dx_en  = 1'b0;
                        w_xm_clr = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_RUN;
            r_wd     <= '0;
            r_md_err <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (!bus.branch_taken && bus.md_start) begin
                        r_state <= ST_MDWAIT;
                        r_wd    <= '0;
                    end
                end
                ST_MDWAIT: begin
                    if (bus.md_ready) begin
                        r_state <= ST_RUN;
                    end else if (w_timeout) begin
                        r_state  <= ST_RUN;
                        r_md_err <= 1'b1;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign bus.pc_en  = w_pc_en;
    assign bus.fd_en  = w_fd_en;
    assign bus.fd_clr = w_fd_clr;
    assign bus.dx_en  = w_dx_en;
    assign bus.dx_clr = w_dx_clr;
    assign bus.xm_clr = w_xm_clr;
    assign bus.md_go  = w_md_go;
    assign bus.md_err = r_md_err;

`ifdef PIPE_STATS_EN
    logic [31:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!w_pc_en) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if ((r_state == ST_RUN) && bus.branch_taken) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
    assign bus.flush_cnt = r_flush_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Self-checking bench: vector table, directed multdiv/watchdog/
//               reset sequences and randomized run against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;
    localparam int RB  = 5;
    localparam int MDM = 8;
    localparam int CW  = 4;

    // Output vector order: {pc_en, fd_en, fd_clr, dx_en, dx_clr, xm_clr, md_go}
    localparam logic [6:0] O_RST  = 7'b0010110;
    localparam logic [6:0] O_RUN  = 7'b1101000;
    localparam logic [6:0] O_BR   = 7'b1111100;
    localparam logic [6:0] O_MD   = 7'b0000011;
    localparam logic [6:0] O_LU   = 7'b0001100;
    localparam logic [6:0] O_WAIT = 7'b0000010;

    typedef struct {
        bit         rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        bit         u2;
        bit         ld;
        logic [4:0] rd;
        bit         br;
        bit         ms;
        bit         mr;
        logic [6:0] exp_o;
        bit         exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_BITS(RB)) bus ();

    pipe_hazard_ctrl #(
        .REG_BITS(RB), .MD_MAX_CYCLES(MDM), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: "busy" while a multdiv is outstanding, plus how many
    // wait cycles have already elapsed since md_go.
    bit          m_busy;
    int          m_waited;
    bit          m_err;
    logic [31:0] m_stall;
    logic [15:0] m_flush;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", n, a, e, $time);
        end
    endtask

    function automatic vec_t mk(bit rst, int rs1, int rs2, bit u2, bit ld, int rd,
                                bit br, bit ms, bit mr, logic [6:0] eo, bit ee);
        vec_t v;
        v.rst = rst; v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.u2 = u2; v.ld = ld;
        v.rd = 5'(rd); v.br = br; v.ms = ms; v.mr = mr; v.exp_o = eo; v.exp_err = ee;
        return v;
    endfunction

    function automatic logic [6:0] model_out(vec_t v);
        logic lu;
        lu = v.ld && (v.rd != 0) && ((v.rs1 == v.rd) || (v.u2 && (v.rs2 == v.rd)));
        if (v.rst) return O_RST;
        if (m_busy) return (v.mr || (m_waited + 1 == MDM)) ? O_RUN : O_WAIT;
        if (v.br) return O_BR;
        if (v.ms) return O_MD;
        if (lu)   return O_LU;
        return O_RUN;
    endfunction

    task automatic model_update(vec_t v, logic [6:0] eo);
        if (v.rst) begin
            m_busy = 0; m_waited = 0; m_err = 0; m_stall = '0; m_flush = '0;
        end else begin
            if (!eo[6]) m_stall = m_stall + 32'd1;
            if (!m_busy && v.br) m_flush = m_flush + 16'd1;
            if (m_busy) begin
                if (v.mr) m_busy = 0;
                else if (m_waited + 1 == MDM) begin m_busy = 0; m_err = 1; end
                else m_waited++;
            end else if (!v.br && v.ms) begin
                m_busy = 1; m_waited = 0;
            end
        end
    endtask

    // One clock: drive at posedge+1, check at negedge, model steps to next edge.
    task automatic step(input vec_t v, output logic [6:0] o, output logic e);
        logic [6:0] eo;
        reset            = v.rst;
        bus.fd_rs1       = v.rs1;
        bus.fd_rs2       = v.rs2;
        bus.fd_uses_rs2  = v.u2;
        bus.dx_is_load   = v.ld;
        bus.dx_rd        = v.rd;
        bus.branch_taken = v.br;
        bus.md_start     = v.ms;
        bus.md_ready     = v.mr;
        @(negedge clk);
        o  = {bus.pc_en, bus.fd_en, bus.fd_clr, bus.dx_en, bus.dx_clr, bus.xm_clr, bus.md_go};
        e  = bus.md_err;
        eo = model_out(v);
        chk("model_outs", {25'd0, o}, {25'd0, eo});
        chk("model_md_err", {31'd0, e}, {31'd0, m_err});
`ifdef PIPE_STATS_EN
        chk("model_stall_cnt", bus.stall_cnt, m_stall);
        chk("model_flush_cnt", {16'd0, bus.flush_cnt}, {16'd0, m_flush});
`endif
        model_update(v, eo);
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[13];
    vec_t idle;
    logic [6:0] o;
    logic e;

    initial begin
        idle = mk(0, 1, 2, 0, 0, 3, 0, 0, 0, O_RUN, 0);
        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, O_RST, 0);
        tbl[1]  = mk(1, 5, 5, 1, 1, 5, 1, 1, 1, O_RST, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN, 0);
        tbl[3]  = mk(0, 5, 1, 0, 1, 5, 0, 0, 0, O_LU,  0);
        tbl[4]  = mk(0, 0, 0, 1, 1, 0, 0, 0, 0, O_RUN, 0);
        tbl[5]  = mk(0, 3, 7, 1, 1, 7, 0, 0, 0, O_LU,  0);
        tbl[6]  = mk(0, 3, 7, 0, 1, 7, 0, 0, 0, O_RUN, 0);
        tbl[7]  = mk(0, 7, 7, 1, 0, 7, 0, 0, 0, O_RUN, 0);
        tbl[8]  = mk(0, 5, 5, 1, 1, 5, 1, 1, 0, O_BR,  0);
        tbl[9]  = mk(0, 1, 2, 0, 0, 3, 0, 1, 0, O_MD,  0);
        tbl[10] = mk(0, 1, 2, 0, 0, 3, 0, 0, 0, O_WAIT, 0);
        tbl[11] = mk(0, 5, 5, 1, 1, 5, 1, 1, 1, O_RUN, 0);
        tbl[12] = mk(0, 5, 5, 1, 1, 5, 0, 0, 0, O_LU,  0);

        // Bring the design out of its unknown power-up state.
        reset = 1'b1;
        bus.fd_rs1 = '0; bus.fd_rs2 = '0; bus.fd_uses_rs2 = 0; bus.dx_is_load = 0;
        bus.dx_rd = '0; bus.branch_taken = 0; bus.md_start = 0; bus.md_ready = 0;
        @(posedge clk); #1;
        model_update(tbl[0], O_RST);

        for (int i = 0; i < 13; i++) begin
            step(tbl[i], o, e);
            chk($sformatf("tbl%0d_outs", i), {25'd0, o}, {25'd0, tbl[i].exp_o});
            chk($sformatf("tbl%0d_md_err", i), {31'd0, e}, {31'd0, tbl[i].exp_err});
        end

        // Multdiv: md_go cycle + 3 wait cycles, release on md_ready.
        begin
            int low_pc, xm_hi, gos;
            vec_t v;
            low_pc = 0; xm_hi = 0; gos = 0;
            for (int c = 0; c < 6; c++) begin
                v = idle;
                v.ms = (c == 0);
                v.mr = (c == 4);
                step(v, o, e);
                if (!o[6]) low_pc++;
                if (o[1])  xm_hi++;
                if (o[0])  gos++;
            end
            chk("md_stall_len", low_pc, 4);
            chk("md_xm_clr_len", xm_hi, 4);
            chk("md_go_pulses", gos, 1);
            chk("md_no_err", {31'd0, e}, 0);
        end

        // Watchdog: md_ready never arrives, release on the 8th wait cycle.
        begin
            int rel_idx;
            vec_t v;
            rel_idx = -1;
            v = idle; v.ms = 1;
            step(v, o, e);
            for (int c = 1; c <= 20 && rel_idx < 0; c++) begin
                step(idle, o, e);
                if (o[6]) rel_idx = c;
            end
            chk("wd_release_cycle", rel_idx, MDM);
            step(idle, o, e);
            chk("wd_err_set", {31'd0, e}, 1);
            v = idle; v.ms = 1;
            step(v, o, e);
            v = idle; v.mr = 1;
            step(v, o, e);
            step(idle, o, e);
            chk("wd_err_sticky", {31'd0, e}, 1);
        end

        // Reset while waiting on multdiv.
        begin
            vec_t v;
            v = idle; v.ms = 1;
            step(v, o, e);
            step(idle, o, e);
            v = idle; v.rst = 1; v.ms = 1;
            step(v, o, e);
            chk("rst_in_wait_outs", {25'd0, o}, {25'd0, O_RST});
            step(idle, o, e);
            chk("after_rst_run", {25'd0, o}, {25'd0, O_RUN});
            chk("after_rst_err", {31'd0, e}, 0);
        end

`ifdef PIPE_STATS_EN
        begin
            vec_t v;
            v = idle; v.rst = 1;
            step(v, o, e);
            step(idle, o, e);
            chk("stats_stall_zero", bus.stall_cnt, 0);
            chk("stats_flush_zero", {16'd0, bus.flush_cnt}, 0);
            v = idle; v.br = 1;
            step(v, o, e);
            step(v, o, e);
            step(idle, o, e);
            chk("stats_flush_two", {16'd0, bus.flush_cnt}, 2);
        end
`endif

        // Randomized run, compared against the model inside step().
        for (int n = 0; n < 3000; n++) begin
            vec_t v;
            v = idle;
            v.rst = ($urandom_range(0, 99) == 0);
            v.rs1 = 5'($urandom_range(0, 7));
            v.rs2 = 5'($urandom_range(0, 7));
            v.rd  = 5'($urandom_range(0, 7));
            v.u2  = $urandom_range(0, 1);
            v.ld  = $urandom_range(0, 1);
            v.br  = ($urandom_range(0, 5) == 0);
            v.ms  = ($urandom_range(0, 4) == 0);
            v.mr  = ($urandom_range(0, 5) == 0);
            step(v, o, e);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
